// File: rtl/thread_chunk_sequencer_if.sv
// Dispatcher <-> thread-lane reroute sequencer bundle.
// master drives launch/status inputs, slave is the sequencer.
interface thread_chunk_sequencer_if #(
    parameter int NUM_LANES = 4,
    parameter int CHUNK_W   = 2,
    parameter int PERF_W    = 32
);
    logic                 start;
    logic [1:0]           cfg_unroll;
    logic [CHUNK_W:0]     cfg_num_chunks;
    logic                 flush;
    logic [NUM_LANES-1:0] ntl_exhausted;
    logic [NUM_LANES-1:0] lane_fifo_valid;
    logic                 cgra_idle;
    logic [1:0]           unrolling_factor;
    logic [CHUNK_W-1:0]   chunk_base_addr;
    logic                 ntl_load;
    logic                 busy;
    logic                 done;
    logic                 aborted;
    logic                 err;
    logic [PERF_W-1:0]    busy_cycles;

    modport master (
        output start, cfg_unroll, cfg_num_chunks, flush,
        output ntl_exhausted, lane_fifo_valid, cgra_idle,
        input  unrolling_factor, chunk_base_addr, ntl_load,
        input  busy, done, aborted, err, busy_cycles
    );

    modport slave (
        input  start, cfg_unroll, cfg_num_chunks, flush,
        input  ntl_exhausted, lane_fifo_valid, cgra_idle,
        output unrolling_factor, chunk_base_addr, ntl_load,
        output busy, done, aborted, err, busy_cycles
    );
endinterface

// File: rtl/thread_chunk_sequencer.sv
// Chunk sequencer for the thread-lane reroute stage: loads, runs
// and drains each chunk so config never changes with TIDs in flight.
module thread_chunk_sequencer #(
    parameter int NUM_LANES = 4,
    parameter int CHUNK_W   = 2,
    parameter int PERF_W    = 32
) (
    input logic clk,
    input logic reset,
    thread_chunk_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, LOAD, SETTLE, RUN, DRAIN, DONE
    } state_t;

    localparam logic [CHUNK_W:0] MAX_CHUNKS = {1'b1, {CHUNK_W{1'b0}}};
    localparam logic [CHUNK_W:0] ONE        = (CHUNK_W+1)'(1);

    state_t               state;
    logic [1:0]           unroll;
    logic [CHUNK_W-1:0]   chunk;
    logic [CHUNK_W:0]     num_chunks;
    logic                 abort_pending;
    logic                 ntl_load;
    logic                 busy;
    logic                 done;
    logic                 aborted;
    logic                 err;
    logic [PERF_W-1:0]    busy_cycles;
    logic                 cfg_legal;
    logic                 last_chunk;
    logic                 drained;
    logic [NUM_LANES-1:0] mask;

    assign cfg_legal = (bus.cfg_unroll != 2'b11)
                    && (bus.cfg_num_chunks != '0)
                    && (bus.cfg_num_chunks <= MAX_CHUNKS);
    assign last_chunk = ({1'b0, chunk} == num_chunks - ONE);

    always_comb begin
        mask = '0;
        unique case (1'b1)
            (unroll == 2'b00): mask = NUM_LANES'(4'b0001);
            (unroll == 2'b01): mask = NUM_LANES'(4'b0011);
            default:           mask = NUM_LANES'(4'b1111);
        endcase
    end

    // only the outputs in use at this unroll factor must be empty
    assign drained = ((bus.lane_fifo_valid & mask) == '0) && bus.cgra_idle;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            unroll        <= '0;
            chunk         <= '0;
            num_chunks    <= '0;
            abort_pending <= 1'b0;
            ntl_load      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            err           <= 1'b0;
            busy_cycles   <= '0;
        end else begin
            ntl_load <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
            if (busy && busy_cycles != '1)
                busy_cycles <= busy_cycles + PERF_W'(1);
            case (state)
                IDLE: begin
                    abort_pending <= 1'b0;
                    if (bus.start) begin
                        if (cfg_legal) begin
                            unroll      <= bus.cfg_unroll;
                            num_chunks  <= bus.cfg_num_chunks;
                            chunk       <= '0;
                            err         <= 1'b0;
                            busy_cycles <= '0;
                            ntl_load    <= 1'b1;
                            busy        <= 1'b1;
                            state       <= LOAD;
                        end else begin
                            err           <= 1'b1;
                            abort_pending <= 1'b1;
                            done          <= 1'b1;
                            aborted       <= 1'b1;
                            state         <= DONE;
                        end
                    end
                end
                LOAD: begin
                    if (bus.flush) begin
                        abort_pending <= 1'b1;
                        state         <= DRAIN;
                    end else begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (bus.flush) begin
                        abort_pending <= 1'b1;
                        state         <= DRAIN;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        abort_pending <= 1'b1;
                        state         <= DRAIN;
                    end else if (&bus.ntl_exhausted) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.flush)
                        abort_pending <= 1'b1;
                    if (drained) begin
                        if (last_chunk || abort_pending || bus.flush) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            aborted <= abort_pending | bus.flush;
                            state   <= DONE;
                        end else begin
                            chunk    <= chunk + 1'b1;
                            ntl_load <= 1'b1;
                            state    <= LOAD;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.unrolling_factor = unroll;
    assign bus.chunk_base_addr  = chunk;
    assign bus.ntl_load         = ntl_load;
    assign bus.busy             = busy;
    assign bus.done             = done;
    assign bus.aborted          = aborted;
    assign bus.err              = err;
    assign bus.busy_cycles      = busy_cycles;
endmodule

// File: tb/tb_thread_chunk_sequencer.sv
// Scoreboard bench: a cycle-timeline model plans every launch and
// a monitor checks each ntl_load / done pulse against it.
module tb_thread_chunk_sequencer;
    localparam int MAXC = 12000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    thread_chunk_sequencer_if #(
        .NUM_LANES(4), .CHUNK_W(2), .PERF_W(32)
    ) bus ();

    thread_chunk_sequencer #(
        .NUM_LANES(4), .CHUNK_W(2), .PERF_W(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        int         issue;
        int         cyc;
        bit         is_done;
        logic [1:0] chunk;
        logic [1:0] uf;
        bit         aborted;
        bit         err;
        int         bc;
    } ev_t;

    ev_t plan_q[$];
    ev_t exp_q[$];

    logic [3:0] s_ex[MAXC];
    logic [3:0] s_lfv[MAXC];
    bit         s_cg[MAXC];
    bit         s_fl[MAXC];
    bit         s_st[MAXC];
    logic [1:0] s_uf[MAXC];
    logic [2:0] s_nc[MAXC];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;
    bit sched  = 1'b1;

    logic [1:0] m_uf    = 2'd0;
    logic [1:0] m_chunk = 2'd0;
    int         m_bc    = 0;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d",
                     name, cyc, act, exp);
        end
    endtask

    function automatic ev_t mk_ev(int issue, int c, bit dn,
                                  logic [1:0] ch, logic [1:0] uf,
                                  bit ab, bit er, int bc);
        ev_t e;
        e.issue = issue; e.cyc = c; e.is_done = dn;
        e.chunk = ch; e.uf = uf; e.aborted = ab;
        e.err = er; e.bc = bc;
        return e;
    endfunction

    // Plans one launch on the absolute cycle timeline.
    task automatic plan_launch(input int t0, input bit [1:0] uf,
                               input bit [2:0] nc, input int fl_chunk,
                               input int emax, input int dmax,
                               output int done_at);
        int t, e, d, f, r, entry, dd, c, last;
        bit ab;
        logic [3:0] mask, v;
        s_st[t0] = 1'b1;
        s_uf[t0] = uf;
        s_nc[t0] = nc;
        s_fl[t0] = 1'($urandom);
        if (uf == 2'd3 || nc == 3'd0 || nc > 3'd4) begin
            done_at = t0 + 1;
            plan_q.push_back(mk_ev(t0, done_at, 1'b1, m_chunk, m_uf,
                                   1'b1, 1'b1, m_bc));
            s_fl[done_at] = 1'($urandom);
            return;
        end
        m_uf = uf;
        mask = 4'((1 << (1 << uf)) - 1);
        t = t0 + 1;
        ab = 1'b0;
        last = 0;
        for (c = 0; c < int'(nc); c++) begin
            last = c;
            plan_q.push_back(mk_ev(t0, t, 1'b0, 2'(c), uf,
                                   1'b0, 1'b0, 0));
            e = $urandom_range(emax, 0);
            r = t + 2 + e;
            for (int k = t + 2; k < r; k++)
                s_ex[k] = 4'($urandom_range(14, 0));
            s_ex[r] = 4'hf;
            entry = r + 1;
            if (c == fl_chunk) begin
                f = $urandom_range(2 + e, 0);
                s_fl[t + f] = 1'b1;
                entry = t + f + 1;
                ab = 1'b1;
            end
            d = $urandom_range(dmax, 0);
            dd = entry + d;
            for (int k = entry; k < dd; k++) begin
                v = 4'($urandom);
                s_cg[k] = 1'($urandom);
                if ((v & mask) == 4'h0 && s_cg[k]) v[0] = 1'b1;
                s_lfv[k] = v;
            end
            s_lfv[dd] = 4'($urandom) & ~mask;
            s_cg[dd] = 1'b1;
            t = dd + 1;
            if (ab) break;
        end
        done_at = t;
        m_chunk = 2'(last);
        m_bc = t - (t0 + 1);
        plan_q.push_back(mk_ev(t0, t, 1'b1, m_chunk, uf, ab,
                               1'b0, m_bc));
        s_fl[done_at] = 1'($urandom);
        // a start while busy (or in DONE) must be ignored
        if ($urandom_range(1, 0) == 1) begin
            f = $urandom_range(done_at, t0 + 1);
            s_st[f] = 1'b1;
        end
    endtask

    task automatic apply(input int k);
        bus.start           = s_st[k];
        bus.cfg_unroll      = s_uf[k];
        bus.cfg_num_chunks  = s_nc[k];
        bus.flush           = s_fl[k];
        bus.ntl_exhausted   = s_ex[k];
        bus.lane_fifo_valid = s_lfv[k];
        bus.cgra_idle       = s_cg[k];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        while (plan_q.size() > 0 && plan_q[0].issue <= cyc)
            exp_q.push_back(plan_q.pop_front());
        if (sched && cyc < MAXC) apply(cyc);
    endtask

    always @(negedge clk) begin
        if (mon_en && (bus.ntl_load || bus.done)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("ev_cycle", cyc, e.cyc);
                chk("ev_is_done", bus.done, e.is_done);
                chk("ev_chunk", bus.chunk_base_addr, e.chunk);
                chk("ev_unroll", bus.unrolling_factor, e.uf);
                chk("ev_err", bus.err, e.err);
                chk("ev_busy", bus.busy, !e.is_done);
                if (e.is_done) begin
                    chk("done_aborted", bus.aborted, e.aborted);
                    chk("done_busy_cycles", bus.busy_cycles, e.bc);
                end
            end
        end
    end

    initial begin
        int t, dn, gap, fc, s;
        bit [1:0] uf;
        bit [2:0] nc;
        for (int k = 0; k < MAXC; k++) begin
            s_ex[k]  = 4'($urandom);
            s_lfv[k] = 4'($urandom);
            s_cg[k]  = 1'($urandom);
            s_fl[k]  = 1'b0;
            s_st[k]  = 1'b0;
            s_uf[k]  = 2'($urandom);
            s_nc[k]  = 3'($urandom);
        end
        t = 5;
        plan_launch(t, 2'd2, 3'd3, -1, 0, 0, dn);
        t = dn + 1;
        plan_launch(t, 2'd1, 3'd1, -1, 0, 3, dn);
        t = dn + 1;
        plan_launch(t, 2'd3, 3'd2, -1, 0, 0, dn);
        t = dn + 1;
        plan_launch(t, 2'd0, 3'd2, -1, 10, 2, dn);
        t = dn + 1;
        plan_launch(t, 2'd2, 3'd4, 0, 3, 5, dn);
        t = dn + 1;
        while (t < MAXC - 200) begin
            uf = 2'($urandom_range(2, 0));
            nc = 3'($urandom_range(4, 1));
            if ($urandom_range(99, 0) < 15) begin
                if ($urandom_range(1, 0) == 1) uf = 2'd3;
                else nc = ($urandom_range(1, 0) == 1) ? 3'd0
                        : 3'($urandom_range(7, 5));
            end
            fc = ($urandom_range(3, 0) == 0)
               ? $urandom_range(int'(nc) - 1, 0) : -1;
            plan_launch(t, uf, nc, fc, 5, 4, dn);
            gap = $urandom_range(2, 0);
            for (int k = dn + 1; k < dn + 1 + gap; k++)
                s_fl[k] = 1'($urandom);
            t = dn + 1 + gap;
        end

        reset = 1'b1;
        apply(0);
        repeat (3) step();
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ntl_load", bus.ntl_load, 0);
        chk("rst_unroll", bus.unrolling_factor, 0);
        chk("rst_chunk", bus.chunk_base_addr, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_aborted", bus.aborted, 0);
        chk("rst_busy_cycles", bus.busy_cycles, 0);
        reset = 1'b0;
        mon_en = 1'b1;
        while (cyc < t + 20) step();

        sched = 1'b0;
        step();
        s = cyc;
        bus.start = 1'b1;
        bus.cfg_unroll = 2'd2;
        bus.cfg_num_chunks = 3'd4;
        bus.flush = 1'b0;
        bus.ntl_exhausted = 4'hf;
        bus.lane_fifo_valid = 4'h0;
        bus.cgra_idle = 1'b0;
        exp_q.push_back(mk_ev(s, s + 1, 1'b0, 2'd0, 2'd2,
                              1'b0, 1'b0, 0));
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        bus.start = 1'b1;
        bus.cfg_unroll = 2'd0;
        bus.cfg_num_chunks = 3'd1;
        @(negedge clk);
        chk("drain_busy", bus.busy, 1);
        chk("drain_chunk", bus.chunk_base_addr, 0);
        step();
        bus.start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("busy_start_ignored_unroll", bus.unrolling_factor, 2);
        chk("busy_start_ignored_busy", bus.busy, 1);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_unroll", bus.unrolling_factor, 0);
        chk("midrst_chunk", bus.chunk_base_addr, 0);
        chk("midrst_busy_cycles", bus.busy_cycles, 0);
        chk("midrst_aborted", bus.aborted, 0);
        repeat (10) step();
        chk("leftover_expected", exp_q.size() + plan_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/thread_chunk_sequencer.md
# thread_chunk_sequencer

Sequencer for the dispatcher's thread-lane reroute stage. It configures the reroute stage's unrolling factor and 2-bit chunk base address, then steps through the chunks of a kernel launch. For each chunk it loads the next-thread logic, waits for every lane to exhaust its thread IDs, and drains the lane FIFOs and CGRA before moving on. This keeps configuration from changing while tagged thread IDs are still in flight. It sits between the dispatcher front end (start/done) and the reroute / next-thread-logic datapath.

## Interface
Parameters:
- NUM_LANES, 4: lanes / FIFOs; fixed at 4.
- CHUNK_W, 2: chunk index width; max chunks = 2^CHUNK_W.
- PERF_W, 32: busy-cycle counter width.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  launch pulse; honoured only in IDLE.
- cfg_unroll  in  2  00=x1, 01=x2, 10=x4, 11=illegal.
- cfg_num_chunks  in  CHUNK_W+1  chunk count, legal 1..2^CHUNK_W.
- flush  in  1  abort request.
- ntl_exhausted  in  NUM_LANES  per-lane next-thread logic has no valid TID left for the current chunk.
- lane_fifo_valid  in  NUM_LANES  reroute FIFO pop_data_valid per output.
- cgra_idle  in  1  downstream CGRA pipeline empty.
- unrolling_factor  out  2  to reroute; held stable while busy.
- chunk_base_addr  out  CHUNK_W  to reroute; current chunk index.
- ntl_load  out  1  one-cycle pulse: next-thread logic reloads for chunk_base_addr.
- busy  out  1  launch in progress.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  valid with done; launch ended by flush.
- err  out  1  sticky illegal-config flag; cleared by next legal start.
- busy_cycles  out  PERF_W  cycles spent busy in last/current launch; saturates.

## Operation
- States: IDLE, LOAD, SETTLE, RUN, DRAIN, DONE. Encoding is free.
- **IDLE**
  - On start with legal config: latch cfg_unroll into unrolling_factor, latch cfg_num_chunks, set chunk_base_addr=0, clear err and busy_cycles, go to LOAD.
  - On start with illegal config (cfg_unroll=11, or cfg_num_chunks=0, or cfg_num_chunks>2^CHUNK_W): set err=1, go to DONE with aborted=1. unrolling_factor is unchanged.
- **LOAD**: ntl_load=1 (Moore); go to SETTLE.
- **SETTLE**: one cycle for the next-thread logic to register its masks; go to RUN.
- **RUN**: wait until &ntl_exhausted; then go to DRAIN.
- **DRAIN**
  - Active output mask: x1 = 4'b0001, x2 = 4'b0011, x4 = 4'b1111.
  - Wait until (lane_fifo_valid & mask)==0 and cgra_idle.
  - If the current chunk is the last one (chunk_base_addr==num_chunks-1) or abort is pending: go to DONE.
  - Otherwise increment chunk_base_addr and go to LOAD.
- **DONE**: done=1 for one cycle, aborted reflects abort_pending; go to IDLE, where abort_pending is cleared.
- **flush**
  - In LOAD, SETTLE or RUN: set abort_pending and go to DRAIN, so in-flight data still drains.
  - In DRAIN: sets abort_pending and stays in DRAIN.
  - In IDLE or DONE: ignored.
- start outside IDLE is ignored.
- busy=1 in LOAD, SETTLE, RUN and DRAIN; busy=0 in IDLE and DONE.
- busy_cycles increments every busy cycle, saturates at all-ones, and holds its value after DONE until the next legal start.

## Timing
- Reset values: state=IDLE, unrolling_factor=00, chunk_base_addr=0, ntl_load=0, busy=0, done=0, aborted=0, err=0, busy_cycles=0.
- Reset mid-launch returns to IDLE next edge, no done pulse.
- Launch sequence: start high in cycle T (IDLE) → LOAD in T+1 (ntl_load=1, busy=1) → SETTLE in T+2 → RUN from T+3.
- RUN exit: exhaustion seen in cycle R → DRAIN in R+1. The drain condition is evaluated from R+1, never in the same cycle as exhaustion.
- DRAIN exit: drain condition true in cycle D → LOAD (next chunk) or DONE in D+1.
- Chunk overhead: minimum 4 cycles per chunk (LOAD, SETTLE, RUN, DRAIN) plus 1 DONE cycle.
- Single-chunk launch with immediate exhaustion and empty FIFOs: done in T+5.
- chunk_base_addr and unrolling_factor change only on the LOAD entry edge (chunk) or the start edge (unroll). They are never changed while any masked FIFO is valid.
- Simultaneous flush and exhaustion in RUN: go to DRAIN with abort_pending=1.
- Illegal start: done and err both high in T+1, aborted=1.

## Test plan
- **Legal x4, 3 chunks, ntl_exhausted held high, FIFOs empty, cgra_idle=1**
  - ntl_load pulses at T+1, T+5, T+9 with chunk_base_addr 0, 1, 2.
  - done at T+13 with aborted=0, busy_cycles=12.
- **x2, 1 chunk, lane_fifo_valid=4'b1100, cgra_idle=1**
  - FIFO bits 2 and 3 are ignored by the mask; done at T+5.
  - Repeat with lane_fifo_valid=4'b0010 for 3 extra cycles: done at T+8.
- **x1, 2 chunks, lane 3 exhaustion delayed 10 cycles in chunk 0**
  - State stays RUN for those cycles.
  - chunk_base_addr is 0 throughout chunk 0 and becomes 1 only at the second ntl_load.
- **Illegal config**
  - start with cfg_unroll=11: done=1, err=1, aborted=1 at T+1, unrolling_factor unchanged.
  - A following legal start clears err.
- **flush in RUN of chunk 0 of a 4-chunk launch with cgra_idle=0 for 5 cycles**
  - Enters DRAIN, stays there 5 cycles, then done with aborted=1.
  - No further ntl_load.
- **reset asserted in DRAIN; start pulse while busy**
  - reset: all outputs at reset values next cycle, no done pulse.
  - start while busy: no effect on chunk_base_addr or the latched chunk count.
